// File: rtl/requant_stage.sv
// Requantizes a signed accumulator stream: scale multiply, rounding right shift, zero point, ReLU, saturation.
// Latency 3 cycles; all stages advance together when the output is free, and in_ready follows that advance.
module requant_stage #(
    parameter int D_W_ACC = 32,
    parameter int D_W_OUT = 8,
    parameter int SCALE_W = 16,
    parameter int SHIFT_W = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_load,
    input  logic [SCALE_W-1:0]         cfg_scale,
    input  logic [SHIFT_W-1:0]         cfg_shift,
    input  logic signed [D_W_OUT-1:0]  cfg_zp,
    input  logic                       cfg_relu,
    output logic                       cfg_err,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [D_W_ACC-1:0]  in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [D_W_OUT-1:0]  out_data,
    output logic                       out_last,
    output logic [15:0]                sat_count
);

    localparam int P_W = D_W_ACC + SCALE_W + 1;
    localparam int Q_W = P_W + 1;
    localparam int R_W = P_W + 2;

    localparam logic signed [D_W_OUT-1:0] O_MAX = {1'b0, {(D_W_OUT-1){1'b1}}};
    localparam logic signed [D_W_OUT-1:0] O_MIN = {1'b1, {(D_W_OUT-1){1'b0}}};
    localparam logic signed [R_W-1:0]     R_MAX = {{(R_W-D_W_OUT){1'b0}}, O_MAX};
    localparam logic signed [R_W-1:0]     R_MIN = {{(R_W-D_W_OUT){1'b1}}, O_MIN};

    logic [SCALE_W-1:0]        scale_q;
    logic [SHIFT_W-1:0]        shift_q;
    logic signed [D_W_OUT-1:0] zp_q;
    logic                      relu_q;

    logic                  v1, l1, v2, l2, clip3;
    logic signed [P_W-1:0] p1;
    logic signed [Q_W-1:0] q2;

    logic adv, accept, cfg_ok;

    logic signed [P_W-1:0]     a_ext, b_ext, p_nx;
    logic [Q_W-1:0]            rnd;
    logic signed [Q_W-1:0]     sum, q_nx;
    logic signed [R_W-1:0]     r;
    logic signed [D_W_OUT-1:0] out_nx;
    logic                      clip_nx;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv & rst_n;
    assign accept   = in_valid & in_ready;
    // Config may only change with nothing in flight, so every stage can read it directly.
    assign cfg_ok   = cfg_load & ~v1 & ~v2 & ~out_valid & ~in_valid;

    assign a_ext = $signed({{(P_W-D_W_ACC){in_data[D_W_ACC-1]}}, in_data});
    assign b_ext = $signed({{(P_W-SCALE_W){1'b0}}, scale_q});
    assign p_nx  = a_ext * b_ext;

    always_comb begin
        rnd  = Q_W'(1) << (shift_q - SHIFT_W'(1));
        sum  = $signed({p1[P_W-1], p1}) + $signed(rnd);
        q_nx = {p1[P_W-1], p1};
        // Shifts at or beyond the product width always round to zero.
        if (shift_q != '0) begin
            if (int'(shift_q) >= P_W) begin
                q_nx = '0;
            end else begin
                q_nx = sum >>> shift_q;
            end
        end
    end

    always_comb begin
        r = $signed({q2[Q_W-1], q2}) + $signed({{(R_W-D_W_OUT){zp_q[D_W_OUT-1]}}, zp_q});
        if (relu_q && r < 0) begin
            r = '0;
        end
        clip_nx = 1'b0;
        out_nx  = r[D_W_OUT-1:0];
        if (r > R_MAX) begin
            out_nx  = O_MAX;
            clip_nx = 1'b1;
        end else if (r < R_MIN) begin
            out_nx  = O_MIN;
            clip_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scale_q <= SCALE_W'(1);
            shift_q <= '0;
            zp_q    <= '0;
            relu_q  <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_load & ~cfg_ok;
            if (cfg_ok) begin
                scale_q <= cfg_scale;
                shift_q <= cfg_shift;
                zp_q    <= cfg_zp;
                relu_q  <= cfg_relu;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            l1        <= 1'b0;
            p1        <= '0;
            v2        <= 1'b0;
            l2        <= 1'b0;
            q2        <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            clip3     <= 1'b0;
        end else if (adv) begin
            v1 <= accept;
            if (accept) begin
                p1 <= p_nx;
                l1 <= in_last;
            end
            v2 <= v1;
            if (v1) begin
                q2 <= q_nx;
                l2 <= l1;
            end
            out_valid <= v2;
            out_last  <= v2 & l2;
            clip3     <= v2 & clip_nx;
            if (v2) begin
                out_data <= out_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (cfg_ok) begin
            sat_count <= '0;
        end else if (out_valid && adv && clip3 && sat_count != 16'hffff) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_requant_stage.sv
// Scoreboard bench for requant_stage: randomized and directed beats against an arithmetic reference model.
module tb_requant_stage;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_load;
    logic [15:0]       cfg_scale;
    logic [5:0]        cfg_shift;
    logic signed [7:0] cfg_zp;
    logic              cfg_relu;
    logic              cfg_err;
    logic              in_valid;
    logic              in_ready;
    logic signed [31:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              out_last;
    logic [15:0]       sat_count;

    requant_stage dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_load(cfg_load), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
        .cfg_zp(cfg_zp), .cfg_relu(cfg_relu), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint d;
        bit     l;
    } exp_t;

    exp_t   sb[$];
    longint bq_data[$];
    bit     bq_last[$];

    int n_checks = 0;
    int n_fail   = 0;

    longint m_scale = 1;
    int     m_shift = 0;
    longint m_zp    = 0;
    bit     m_relu  = 0;
    int     m_sat   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic on the configured scale/shift/zero point.
    task automatic model(input longint d, output longint o, output bit clip);
        longint p, q, rr;
        p = d * m_scale;
        if (m_shift == 0) q = p;
        else q = (p + (longint'(1) <<< (m_shift - 1))) >>> m_shift;
        rr = q + m_zp;
        if (m_relu && rr < 0) rr = 0;
        clip = 0;
        if (rr > 127) begin rr = 127; clip = 1; end
        else if (rr < -128) begin rr = -128; clip = 1; end
        o = rr;
    endtask

    task automatic burst();
        longint o;
        bit     c;
        bit     ok;
        while (bq_data.size() > 0) begin
            in_valid = 1'b1;
            in_data  = 32'(bq_data[0]);
            in_last  = bq_last[0];
            ok = 0;
            for (int k = 0; k < 200; k++) begin
                @(negedge clk);
                if (in_ready) begin ok = 1; break; end
            end
            if (!ok) begin
                chk("in_ready_timeout", 0, 1);
                void'(bq_data.pop_front());
                void'(bq_last.pop_front());
                continue;
            end
            @(posedge clk);
            model(bq_data[0], o, c);
            if (c && m_sat < 65535) m_sat++;
            sb.push_back('{d: o, l: bq_last[0]});
            void'(bq_data.pop_front());
            void'(bq_last.pop_front());
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input longint d, input bit l);
        bq_data.push_back(d);
        bq_last.push_back(l);
        burst();
    endtask

    task automatic drain();
        bit ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin ok = 1; break; end
        end
        if (!ok) chk("drain_timeout", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic cfg(input int sc, input int sh, input int zp, input bit rl, input bit exp_err);
        cfg_load  = 1'b1;
        cfg_scale = 16'(sc);
        cfg_shift = 6'(sh);
        cfg_zp    = 8'(zp);
        cfg_relu  = rl;
        @(posedge clk); #1;
        cfg_load = 1'b0;
        chk("cfg_err_pulse", cfg_err, exp_err);
        if (!exp_err) begin
            m_scale = sc; m_shift = sh; m_zp = zp; m_relu = rl; m_sat = 0;
        end
        @(posedge clk); #1;
        chk("cfg_err_one_cycle", cfg_err, 0);
    endtask

    // Monitor: pops the scoreboard on each output handshake and checks stability under stall.
    initial begin
        bit          hold = 0;
        logic [7:0]  hd;
        logic        hl;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 0;
            end else begin
                if (hold) begin
                    chk("stall_valid_held", out_valid, 1);
                    chk("stall_data_stable", out_data, $signed(hd));
                    chk("stall_last_stable", out_last, hl);
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", out_data, -999);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("out_last", out_last, e.l);
                    end
                end
                hold = out_valid && !out_ready;
                hd = out_data;
                hl = out_last;
            end
        end
    end

    initial begin
        int k;
        bit done;
        rst_n = 0; cfg_load = 0; cfg_scale = 0; cfg_shift = 0; cfg_zp = 0; cfg_relu = 0;
        in_valid = 0; in_data = 0; in_last = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        @(posedge clk); #1 rst_n = 1;
        @(posedge clk); #1;

        // Defaults, with a latency measurement on the first beat.
        send(100, 0);
        k = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin k = i; break; end
        end
        chk("latency_cycles", k, 3);
        @(posedge clk); #1;
        send(300, 0);
        send(-300, 0);
        drain();
        chk("sat_defaults", sat_count, m_sat);

        cfg(3, 2, 0, 0, 0);
        chk("sat_cleared_on_cfg", sat_count, 0);
        send(5, 0); send(-5, 0); send(-6, 0); send(2, 0);
        drain();

        cfg(1, 0, 10, 1, 0);
        send(-20, 0);
        drain();
        chk("relu_not_counted", sat_count, m_sat);
        send(120, 0);
        drain();
        chk("sat_after_clip", sat_count, m_sat);

        // Backpressure mid-stream over a six-beat packet.
        cfg(1, 0, 0, 0, 0);
        foreach (bq_data[i]) ;
        bq_data = '{10, -200, 30, 400, -50, 60};
        bq_last = '{0, 0, 0, 0, 0, 1};
        fork
            burst();
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1;
            end
        join
        drain();
        chk("sat_backpressure", sat_count, m_sat);

        // Rejected load while the pipeline is busy.
        send(500, 0);
        drain();
        send(7, 0);
        @(posedge clk); #1;
        cfg(3, 0, 0, 0, 1);
        send(20, 0);
        send(-1, 0);
        drain();
        chk("sat_kept_after_reject", sat_count, m_sat);

        // Randomized configs, data and output backpressure.
        for (int rnd = 0; rnd < 4; rnd++) begin
            cfg(int'($urandom_range(0, 65535)), int'($urandom_range(0, 24)),
                int'($urandom_range(0, 255)) - 128, 1'($urandom_range(0, 1)), 0);
            for (int i = 0; i < 25; i++) begin
                if ($urandom_range(0, 1) == 1) bq_data.push_back(longint'($signed($urandom())));
                else bq_data.push_back(longint'($urandom_range(0, 4000)) - 2000);
                bq_last.push_back(i == 24);
            end
            done = 0;
            fork
                begin burst(); done = 1; end
                begin
                    while (!done) begin
                        @(posedge clk);
                        #1 out_ready = ($urandom_range(0, 3) != 0);
                    end
                    out_ready = 1;
                end
            join
            drain();
            chk("sat_random", sat_count, m_sat);
        end

        // Reset with three beats in flight.
        out_ready = 0;
        bq_data = '{11, 22, 33};
        bq_last = '{0, 0, 1};
        burst();
        chk("inflight_before_reset", out_valid, 1);
        rst_n = 0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_sat_count", sat_count, 0);
        sb.delete();
        m_scale = 1; m_shift = 0; m_zp = 0; m_relu = 0; m_sat = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_output_after_reset", out_valid, 0);
        end
        @(posedge clk); #1;
        send(300, 0);
        send(-5, 1);
        drain();
        chk("sat_after_reset_defaults", sat_count, m_sat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/requant_stage.md
REQUANT_STAGE -- requirements
Module: requant_stage

Interface
REQ-001 SHALL have parameter D_W_ACC, default 32: signed accumulator input width.
REQ-002 SHALL have parameter D_W_OUT, default 8: signed output width.
REQ-003 SHALL have parameter SCALE_W, default 16: unsigned multiplier width.
REQ-004 SHALL have parameter SHIFT_W, default 6: right-shift amount width.
REQ-005 SHALL have port clk  input  1: the only clock; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port rst_n  input  1: asynchronous active-low reset.
REQ-007 SHALL have port cfg_load  input  1: load configuration this cycle.
REQ-008 SHALL have port cfg_scale  input  SCALE_W: unsigned scale.
REQ-009 SHALL have port cfg_shift  input  SHIFT_W: right shift amount.
REQ-010 SHALL have port cfg_zp  input  D_W_OUT: signed zero point.
REQ-011 SHALL have port cfg_relu  input  1: clamp negative results to zero.
REQ-012 SHALL have port cfg_err  output  1: one-cycle pulse, cfg_load rejected.
REQ-013 SHALL have port in_valid  input  1, in_ready  output  1, in_data  input  D_W_ACC signed, in_last  input  1: accumulator result stream from the MAC array.
REQ-014 SHALL have port out_valid  output  1, out_ready  input  1, out_data  output  D_W_OUT signed, out_last  output  1: requantized stream.
REQ-015 SHALL have port sat_count  output  16: saturation event counter.

Function
REQ-016 SHALL implement a 3-stage pipeline: S1 multiply, S2 round/shift, S3 zero point/ReLU/saturate; each stage holds a valid bit, data and last.
REQ-017 SHALL advance all stages together when adv = out_ready OR NOT out_valid; otherwise SHALL hold every stage unchanged.
REQ-018 SHALL drive in_ready = adv combinationally; a beat is accepted when in_valid AND in_ready.
REQ-019 SHALL, with out_ready held high, present a beat accepted at cycle t on out_data at cycle t+3.
REQ-020 SHALL, with out_valid high and out_ready low, keep out_data and out_last stable.
REQ-021 S1 SHALL compute p = in_data * signed({1'b0,cfg_scale}) at full width D_W_ACC+SCALE_W+1.
REQ-022 S2 SHALL compute q = (p + 2^(shift-1)) >>> shift when shift>0, else q = p: arithmetic shift, round half toward +inf.
REQ-023 S3 SHALL compute r = q + cfg_zp (sign-extended), then r = max(r,0) if relu, then saturate to [-2^(D_W_OUT-1), 2^(D_W_OUT-1)-1].
REQ-024 S3 SHALL increment sat_count by 1 when a valid beat advances out of S3 and clipping occurred; sat_count SHALL stick at 65535.
REQ-025 ReLU clamping SHALL NOT count as saturation.
REQ-026 SHALL carry in_last to out_last with the same latency as data.
REQ-027 SHALL accept cfg_load only when all three stage valid bits are 0 and in_valid is 0; the new config SHALL apply from the next accepted beat.
REQ-028 SHALL ignore cfg_load otherwise, keep the old config, and pulse cfg_err for one cycle.
REQ-029 SHALL clear sat_count on an accepted cfg_load.
REQ-030 SHALL emit nothing for bubbles: stage valid bits propagate as 0 when no beat is accepted.

Reset
REQ-031 SHALL, on rst_n low, asynchronously clear all stage valid bits, out_valid, out_last, out_data, cfg_err and sat_count to 0.
REQ-032 SHALL, on rst_n low, reset the config to scale=1, shift=0, zp=0, relu=0.
REQ-033 SHALL discard in-flight beats on reset mid-stream and not emit them after rst_n rises.
REQ-034 SHALL hold in_ready low while rst_n is low.

Verification
REQ-035 Reset defaults, out_ready=1: in 100, 300, -300 -> out 100, 127, -128 at t+3 each; sat_count=2.
REQ-036 cfg scale=3, shift=2, zp=0: in 5, -5, -6 -> out 4, -4, -4; in 2 -> out 2 (6+2=8, >>2 = 2).
REQ-037 cfg scale=1, shift=0, zp=10, relu=1: in -20 -> 0, sat_count unchanged; in 120 -> 127, sat_count +1.
REQ-038 Backpressure: 6 beats with in_last on the 6th, out_ready low for 4 cycles mid-stream -> all 6 delivered in order, none dropped or duplicated, out_data stable while stalled, out_last only on the 6th.
REQ-039 cfg_load while S2 holds a valid beat -> cfg_err pulse, old scale used for all subsequent beats, sat_count not cleared.
REQ-040 rst_n asserted with 3 beats in flight -> out_valid 0 immediately, no outputs after release, config back to defaults.
